// File: rtl/param_heap_pq_if.sv
// Request/response bundle for param_heap_pq: enqueue/dequeue handshake, top item and occupancy.
// The queue takes the slave side; the scheduler driving it takes the master side.
interface param_heap_pq_if #(
    parameter int unsigned KEY_WIDTH = 16,
    parameter int unsigned VAL_WIDTH = 16,
    parameter int unsigned LEVELS    = 4
);
    logic                 enq;
    logic                 deq;
    logic [KEY_WIDTH-1:0] key_i;
    logic [VAL_WIDTH-1:0] val_i;
    logic [KEY_WIDTH-1:0] key_o;
    logic [VAL_WIDTH-1:0] val_o;
    logic [LEVELS-1:0]    count;
    logic                 empty;
    logic                 full;
    logic                 busy;

    modport master (
        output enq, deq, key_i, val_i,
        input  key_o, val_o, count, empty, full, busy
    );

    modport slave (
        input  enq, deq, key_i, val_i,
        output key_o, val_o, count, empty, full, busy
    );
endinterface

// File: rtl/param_heap_pq.sv
// Binary-heap priority queue over a single-port RAM, min- or max-heap, with atomic replace.
// Operations are multi-cycle; requests are only taken while busy is low.
module param_heap_pq #(
    parameter int unsigned KEY_WIDTH = 16,
    parameter int unsigned VAL_WIDTH = 16,
    parameter int unsigned LEVELS    = 4,
    parameter int unsigned MAX_HEAP  = 0
) (
    input logic            clk,
    input logic            rst,
    param_heap_pq_if.slave bus
);
    localparam int unsigned CAP = (1 << LEVELS) - 1;
    localparam int unsigned IW  = LEVELS + 1;

    typedef struct packed {
        logic [KEY_WIDTH-1:0] key;
        logic [VAL_WIDTH-1:0] val;
    } item_t;

    typedef enum logic [3:0] {
        StIdle, StEnqWr, StUpRd, StUpCmp, StUpWr, StDqRd,
        StDqWr, StDnRdl, StDnRdr, StDnCmp, StDnWr1, StDnWr2
    } state_e;

    state_e            state_q, state_d;
    logic [LEVELS-1:0] count_q, idx_q, child_q, parent;
    logic [IW-1:0]     lidx, ridx, count_ext;
    item_t             item_q, other_q, left_q, top_q, rdata_q, ram_wdata, cand;
    logic              left_better_q, right_ok_q, rep_q;
    logic              ram_we, ram_re;
    logic [LEVELS-1:0] ram_addr;
    logic              idle, empty_w, full_w, acc_enq, acc_deq, acc_rep;
    logic              up_swap, right_pick, dn_swap;

    item_t mem [0:CAP];

    function automatic logic better(input logic [KEY_WIDTH-1:0] a,
                                    input logic [KEY_WIDTH-1:0] b);
        return (MAX_HEAP != 0) ? (a > b) : (a < b);
    endfunction

    // Slot 0 is never addressed; indices stay within LEVELS bits, children use LEVELS+1.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (ram_re) rdata_q <= mem[ram_addr];
    end

    assign parent    = idx_q >> 1;
    assign lidx      = {idx_q, 1'b0};
    assign ridx      = {idx_q, 1'b1};
    assign count_ext = {1'b0, count_q};
    assign idle      = (state_q == StIdle);
    assign empty_w   = (count_q == '0);
    assign full_w    = (count_q == LEVELS'(CAP));

    assign acc_enq = idle && bus.enq && (bus.deq ? empty_w : !full_w);
    assign acc_deq = idle && bus.deq && !bus.enq && !empty_w;
    assign acc_rep = idle && bus.deq && bus.enq && !empty_w;

    assign up_swap    = better(item_q.key, rdata_q.key);
    // Right only displaces the current winner when strictly better, so ties go left.
    assign cand       = left_better_q ? left_q : item_q;
    assign right_pick = right_ok_q && better(rdata_q.key, cand.key);
    assign dn_swap    = right_pick || left_better_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (acc_enq)      state_d = StEnqWr;
                else if (acc_deq) state_d = StDqRd;
                else if (acc_rep) state_d = StDqWr;
            end
            StEnqWr: state_d = (idx_q == LEVELS'(1)) ? StIdle : StUpRd;
            StUpRd:  state_d = StUpCmp;
            StUpCmp: state_d = up_swap ? StUpWr : StIdle;
            StUpWr:  state_d = (parent == LEVELS'(1)) ? StIdle : StUpRd;
            StDqRd:  state_d = (idx_q == LEVELS'(1)) ? StIdle : StDqWr;
            StDqWr:  state_d = StDnRdl;
            StDnRdl: state_d = (lidx > count_ext) ? StIdle : StDnRdr;
            StDnRdr: state_d = StDnCmp;
            StDnCmp: state_d = dn_swap ? StDnWr1 : StIdle;
            StDnWr1: state_d = StDnWr2;
            StDnWr2: state_d = StDnRdl;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = idx_q;
        ram_wdata = item_q;
        unique case (state_q)
            StEnqWr: ram_we = 1'b1;
            StUpRd: begin
                ram_re   = 1'b1;
                ram_addr = parent;
            end
            StUpCmp: begin
                ram_we   = up_swap;
                ram_addr = parent;
            end
            StUpWr: begin
                ram_we    = 1'b1;
                ram_wdata = other_q;
            end
            StDqRd: ram_re = 1'b1;
            StDqWr: begin
                ram_we    = 1'b1;
                ram_addr  = LEVELS'(1);
                ram_wdata = rep_q ? item_q : rdata_q;
            end
            StDnRdl: begin
                ram_re   = (lidx <= count_ext);
                ram_addr = lidx[LEVELS-1:0];
            end
            StDnRdr: begin
                ram_re   = (ridx <= count_ext);
                ram_addr = ridx[LEVELS-1:0];
            end
            StDnWr1: begin
                ram_we    = 1'b1;
                ram_wdata = other_q;
            end
            StDnWr2: begin
                ram_we   = 1'b1;
                ram_addr = child_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            idx_q         <= '0;
            child_q       <= '0;
            item_q        <= '0;
            other_q       <= '0;
            left_q        <= '0;
            top_q         <= '0;
            left_better_q <= 1'b0;
            right_ok_q    <= 1'b0;
            rep_q         <= 1'b0;
        end else begin
            if (ram_we && ram_addr == LEVELS'(1)) top_q <= ram_wdata;
            case (state_q)
                StIdle: begin
                    if (acc_enq) begin
                        count_q <= count_q + 1'b1;
                        idx_q   <= count_q + 1'b1;
                        item_q  <= '{key: bus.key_i, val: bus.val_i};
                        rep_q   <= 1'b0;
                    end else if (acc_deq) begin
                        count_q <= count_q - 1'b1;
                        idx_q   <= count_q;
                        rep_q   <= 1'b0;
                    end else if (acc_rep) begin
                        item_q <= '{key: bus.key_i, val: bus.val_i};
                        rep_q  <= 1'b1;
                    end
                end
                StUpCmp: other_q <= rdata_q;
                StUpWr:  idx_q <= parent;
                StDqWr: begin
                    if (!rep_q) item_q <= rdata_q;
                    idx_q <= LEVELS'(1);
                end
                StDnRdr: begin
                    left_q        <= rdata_q;
                    left_better_q <= better(rdata_q.key, item_q.key);
                    right_ok_q    <= (ridx <= count_ext);
                end
                StDnCmp: begin
                    other_q <= right_pick ? rdata_q : left_q;
                    child_q <= right_pick ? ridx[LEVELS-1:0] : lidx[LEVELS-1:0];
                end
                StDnWr2: idx_q <= child_q;
                default: ;
            endcase
        end
    end

    assign bus.key_o = top_q.key;
    assign bus.val_o = top_q.val;
    assign bus.count = count_q;
    assign bus.empty = empty_w;
    assign bus.full  = full_w;
    assign bus.busy  = !idle;
endmodule

// File: tb/tb_param_heap_pq.sv
// Directed bench for param_heap_pq: a min-heap and a max-heap instance (LEVELS=3) driven
// from a vector table, plus hand sequences for reset behaviour and mid-operation reset.
module tb_param_heap_pq;
    localparam int unsigned KW  = 8;
    localparam int unsigned VW  = 8;
    localparam int unsigned LV  = 3;
    localparam int          CAP = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bit            mx_sel = 1'b0;
    logic          drv_enq = 1'b0, drv_deq = 1'b0;
    logic [KW-1:0] drv_key = '0;
    logic [VW-1:0] drv_val = '0;

    param_heap_pq_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .LEVELS(LV)) if_min ();
    param_heap_pq_if #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .LEVELS(LV)) if_max ();

    param_heap_pq #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .LEVELS(LV), .MAX_HEAP(0)) u_min (
        .clk (clk),
        .rst (rst),
        .bus (if_min)
    );
    param_heap_pq #(.KEY_WIDTH(KW), .VAL_WIDTH(VW), .LEVELS(LV), .MAX_HEAP(1)) u_max (
        .clk (clk),
        .rst (rst),
        .bus (if_max)
    );

    assign if_min.enq   = drv_enq & ~mx_sel;
    assign if_min.deq   = drv_deq & ~mx_sel;
    assign if_max.enq   = drv_enq & mx_sel;
    assign if_max.deq   = drv_deq & mx_sel;
    assign if_min.key_i = drv_key;
    assign if_min.val_i = drv_val;
    assign if_max.key_i = drv_key;
    assign if_max.val_i = drv_val;

    logic [KW-1:0] s_key;
    logic [VW-1:0] s_val;
    logic [LV-1:0] s_count;
    logic          s_empty, s_full, s_busy;
    assign s_key   = mx_sel ? if_max.key_o : if_min.key_o;
    assign s_val   = mx_sel ? if_max.val_o : if_min.val_o;
    assign s_count = mx_sel ? if_max.count : if_min.count;
    assign s_empty = mx_sel ? if_max.empty : if_min.empty;
    assign s_full  = mx_sel ? if_max.full  : if_min.full;
    assign s_busy  = mx_sel ? if_max.busy  : if_min.busy;

    typedef struct {
        bit mx;
        bit e;
        bit d;
        int key;
        int ret;   // expected returned top key, -1 = not checked
        int top;   // expected top key afterwards, -1 = not checked
        int cnt;
        int bcyc;  // expected busy cycles, -1 = not checked
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input bit mx, input bit e, input bit d, input int key, input int ret,
                       input int top, input int cnt, input int bcyc);
        vec_t v;
        v.mx = mx; v.e = e; v.d = d; v.key = key;
        v.ret = ret; v.top = top; v.cnt = cnt; v.bcyc = bcyc;
        vecs.push_back(v);
    endtask

    // Entered and left just after a falling edge.
    task automatic apply(input bit mx, input bit e, input bit d, input int key,
                         output int ret_k, output int ret_v, output int bc);
        int guard;
        mx_sel = mx;
        #1;
        guard = 0;
        while (s_busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (s_busy) check("idle_timeout", int'(s_busy), 0);
        drv_enq = e;
        drv_deq = d;
        drv_key = KW'(key);
        drv_val = VW'(key + 100);
        ret_k   = int'(s_key);
        ret_v   = int'(s_val);
        @(posedge clk);
        #1;
        drv_enq = 1'b0;
        drv_deq = 1'b0;
        bc = 0;
        @(negedge clk);
        while (s_busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        if (s_busy) check("busy_timeout", int'(s_busy), 0);
    endtask

    initial begin
        vec_t v;
        int   rk, rv, bc;

        // MIN heap: enqueue, then drain in sorted order
        add(0, 1, 0, 5, -1, 5, 1, 1);
        add(0, 1, 0, 3, -1, 3, 2, -1);
        add(0, 1, 0, 8, -1, 3, 3, -1);
        add(0, 1, 0, 1, -1, 1, 4, -1);
        add(0, 1, 0, 9, -1, 1, 5, -1);
        add(0, 1, 0, 2, -1, 1, 6, -1);
        add(0, 0, 1, 0, 1, 2, 5, -1);
        add(0, 0, 1, 0, 2, 3, 4, -1);
        add(0, 0, 1, 0, 3, 5, 3, -1);
        add(0, 0, 1, 0, 5, 8, 2, -1);
        add(0, 0, 1, 0, 8, 9, 1, -1);
        add(0, 0, 1, 0, 9, -1, 0, 1);
        // Fill to capacity, overfill is ignored, replace over the top, drain
        add(0, 1, 0, 4, -1, 4, 1, 1);
        add(0, 1, 0, 6, -1, 4, 2, -1);
        add(0, 1, 0, 1, -1, 1, 3, -1);
        add(0, 1, 0, 7, -1, 1, 4, -1);
        add(0, 1, 0, 2, -1, 1, 5, -1);
        add(0, 1, 0, 9, -1, 1, 6, -1);
        add(0, 1, 0, 3, -1, 1, 7, -1);
        add(0, 1, 0, 0, -1, 1, 7, 0);
        add(0, 1, 1, 50, 1, 2, 7, -1);
        add(0, 0, 1, 0, 2, 3, 6, -1);
        add(0, 0, 1, 0, 3, 4, 5, -1);
        add(0, 0, 1, 0, 4, 6, 4, -1);
        add(0, 0, 1, 0, 6, 7, 3, -1);
        add(0, 0, 1, 0, 7, 9, 2, -1);
        add(0, 0, 1, 0, 9, 50, 1, -1);
        add(0, 0, 1, 0, 50, -1, 0, 1);
        // enq & deq on empty acts as a plain enqueue
        add(0, 1, 1, 11, -1, 11, 1, 1);
        add(0, 0, 1, 0, 11, -1, 0, 1);
        // MAX heap with duplicate keys
        add(1, 1, 0, 4, -1, 4, 1, 1);
        add(1, 1, 0, 4, -1, 4, 2, -1);
        add(1, 1, 0, 7, -1, 7, 3, -1);
        add(1, 1, 0, 4, -1, 7, 4, -1);
        add(1, 0, 1, 0, 7, 4, 3, -1);
        add(1, 0, 1, 0, 4, 4, 2, -1);
        add(1, 0, 1, 0, 4, 4, 1, -1);
        add(1, 0, 1, 0, 4, -1, 0, 1);

        // Reset and idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_count", int'(if_min.count), 0);
        check("rst_empty", int'(if_min.empty), 1);
        check("rst_full", int'(if_min.full), 0);
        check("rst_busy", int'(if_min.busy), 0);
        check("rst_key", int'(if_min.key_o), 0);
        check("rst_val", int'(if_min.val_o), 0);
        check("rst_max_key", int'(if_max.key_o), 0);

        // Dequeue on empty is ignored
        mx_sel  = 1'b0;
        drv_deq = 1'b1;
        @(posedge clk);
        #1;
        drv_deq = 1'b0;
        @(negedge clk);
        check("deq_empty_count", int'(s_count), 0);
        check("deq_empty_busy", int'(s_busy), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            apply(v.mx, v.e, v.d, v.key, rk, rv, bc);
            if (v.ret >= 0) begin
                check($sformatf("v%0d_ret_key", i), rk, v.ret);
                check($sformatf("v%0d_ret_val", i), rv, v.ret + 100);
            end
            check($sformatf("v%0d_count", i), int'(s_count), v.cnt);
            check($sformatf("v%0d_empty", i), int'(s_empty), (v.cnt == 0) ? 1 : 0);
            check($sformatf("v%0d_full", i), int'(s_full), (v.cnt == CAP) ? 1 : 0);
            if (v.top >= 0) begin
                check($sformatf("v%0d_top_key", i), int'(s_key), v.top);
                check($sformatf("v%0d_top_val", i), int'(s_val), v.top + 100);
            end
            if (v.bcyc >= 0) check($sformatf("v%0d_busy_cycles", i), bc, v.bcyc);
        end

        // Reset in the middle of a dequeue sift-down
        for (int k = 1; k <= 5; k++) apply(0, 1, 0, k, rk, rv, bc);
        check("pre_rst_count", int'(s_count), 5);
        drv_deq = 1'b1;
        @(posedge clk);
        #1;
        drv_deq = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_deq_busy", int'(s_busy), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_count", int'(s_count), 0);
        check("abort_busy", int'(s_busy), 0);
        check("abort_empty", int'(s_empty), 1);
        check("abort_key", int'(s_key), 0);
        apply(0, 1, 0, 6, rk, rv, bc);
        check("post_abort_key", int'(s_key), 6);
        check("post_abort_count", int'(s_count), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/param_heap_pq.md
# param_heap_pq

Parametrised binary-heap priority queue holding key/value pairs in a single-port synchronous RAM, with a min- or max-heap mode, an atomic replace (enqueue+dequeue in one request) and an occupancy count. It is the general-purpose successor to the fixed-width heap queue in the priority-queue library. It sits behind schedulers that tolerate multi-cycle operations and respect a `busy` handshake.

## Interface
- `KEY_WIDTH`, default 16: key width in bits; compared unsigned.
- `VAL_WIDTH`, default 16: value width in bits; payload only, never compared.
- `LEVELS`, default 4: number of heap levels. Capacity is `CAP = 2**LEVELS-1`. Legal range is 1..16.
- `MAX_HEAP`, default 0: 0 means the smallest key is on top; 1 means the largest key is on top.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `enq`  in  1: enqueue request; sampled only when `busy`=0.
- `deq`  in  1: dequeue request; sampled only when `busy`=0.
- `key_i`  in  KEY_WIDTH: key to enqueue.
- `val_i`  in  VAL_WIDTH: value to enqueue.
- `key_o`  out  KEY_WIDTH: key of the top item.
- `val_o`  out  VAL_WIDTH: value of the top item.
- `count`  out  LEVELS: number of items stored, 0..CAP.
- `empty`  out  1: `count`==0.
- `full`  out  1: `count`==CAP.
- `busy`  out  1: an operation is in progress and requests are ignored.

## Operation
- Storage is a RAM of `CAP` words addressed 1..CAP (`parent`=i>>1, `left`=2i, `right`=2i+1). Read latency is 1 cycle; at most one read or one write per cycle.
- A `top` register mirrors slot 1. It is loaded whenever slot 1 is written, and drives `key_o`/`val_o`.
- "Better(a,b)": a.key<b.key when `MAX_HEAP`=0; a.key>b.key when `MAX_HEAP`=1. Equal keys are never swapped. On a tie between children, left wins.
- Request decode (only when `busy`=0):
  - `enq` & !`deq` & !`full`: ENQ.
  - `deq` & !`enq` & !`empty`: DEQ.
  - `enq` & `deq` & !`empty`: REPLACE. Valid when `full`.
  - `enq` & `deq` & `empty`: ENQ.
  - Anything else is ignored. No flag or state changes.
- FSM states: IDLE, ENQ_WR, UP_RD, UP_CMP, UP_WR, DQ_RD, DQ_WR, DN_RDL, DN_RDR, DN_CMP, DN_WR1, DN_WR2.
- ENQ, from IDLE:
  - IDLE: `count`+1. Latch the new item and i=new `count`.
  - ENQ_WR: write the new item to slot i. If i==1 go to IDLE, else go to UP_RD.
  - UP_RD: read parent(i).
  - UP_CMP: if !Better(new, parent) go to IDLE. Otherwise write the new item to parent(i), latch the parent item, and go to UP_WR.
  - UP_WR: write the parent item to slot i; i=parent(i). If i==1 go to IDLE, else go to UP_RD.
- DEQ, from IDLE:
  - IDLE: `count`-1.
  - DQ_RD: read slot old `count`. If old `count`==1 go straight to IDLE.
  - DQ_WR: write that item to slot 1; i=1. Go to DN_RDL.
- REPLACE, from IDLE: `count` is unchanged. Write the new item to slot 1; i=1. Go to DN_RDL.
- Sift-down:
  - DN_RDL: if left(i)>`count` go to IDLE; else read it.
  - DN_RDR: compare the left child. Read right(i) if it is ≤`count`.
  - DN_CMP: pick the best of {item, left, right}. If the item is best, go to IDLE.
  - DN_WR1: write the child to slot i.
  - DN_WR2: write the item to the child slot; i=child. Go to DN_RDL.
- `key_o`/`val_o` are valid only when `busy`=0 and `empty`=0. When `empty`=1 they are stale and undefined.
- Child indices are computed with LEVELS+1 bits so that 2i never wraps.

## Timing
- Reset values:
  - `count`=0, `empty`=1, `full`=0, `busy`=0.
  - `key_o`=0, `val_o`=0.
  - FSM in IDLE. RAM contents are don't-care.
- Acceptance happens on the rising edge where `busy`=0 and a legal request is present.
- `count`/`empty`/`full` update on that same edge. `busy`=1 from the next cycle until the operation completes.
- The returned (old) top is the `key_o`/`val_o` value presented in the acceptance cycle. The new top is valid on the first cycle `busy`=0.
- Busy durations:
  - ENQ into empty: 1 cycle.
  - ENQ otherwise: between 3 cycles and 1+3·(LEVELS-1).
  - DEQ of the last item: 1 cycle.
  - DEQ otherwise: 2 + sift-down.
  - REPLACE: 1 + sift-down.
  - Sift-down: ≤ 5 cycles per level descended, plus a final ≤3.
- `rst` asserted during any state aborts the operation. Outputs take their reset values on the next edge.

## Test plan
- Reset, idle 5 cycles: `count`=0, `empty`=1, `busy`=0, `key_o`=0. `deq` is ignored and `count` stays 0.
- MIN mode, LEVELS=3: ENQ keys 5,3,8,1,9,2 (val=key+100), each after `busy` falls. `key_o` after each = 5,3,3,1,1,1. Six DEQs return 1,2,3,5,8,9 with matching vals, then `empty`=1.
- Fill LEVELS=3 with 7 keys: `full`=1. An 8th `enq` leaves `count`=7 and `busy`=0. REPLACE key 50 over top 1: `count`=7, `key_o`=2 afterwards.
- MAX_HEAP=1: ENQ 4,4,7,4. `key_o`=7. DEQ order is 7,4,4,4. Values in equal-key order are not checked.
- `enq`&`deq` when `empty`: behaves as ENQ, `count`=1. Busy-length check: ENQ into empty gives `busy` high for exactly 1 cycle.
- Assert `rst` in the middle of a DEQ sift-down: next cycle `count`=0, `busy`=0. A following ENQ 6 gives `key_o`=6.
